bus_wait_responder: RTL and testbench

- Responder end of the microcode sequencer's bus-cycle interface.
- Decodes the sequencer's per-microinstruction nmem/nio/nr/nwen outputs and inserts programmable wait states plus device-requested waits by driving nws low, which holds the µPC.
- Generates timed read and write strobes and times out stuck external waits.
- Sits on the control board between the sequencer and the memory/IO bus.

---
 rtl/bus_wait_responder.sv | 136 +++++++++++++
 tb/tb_bus_wait_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_wait_responder.sv
// Responder side of the sequencer bus-cycle handshake: decodes nmem/nio/nr/nwen,
// stretches cycles with nws, times the read/write strobes and flags stuck waits.
module bus_wait_responder #(
  parameter int unsigned MEM_WS  = 0,
  parameter int unsigned IO_WS   = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk4,
  input  logic nreset,
  input  logic nmem,
  input  logic nio,
  input  logic nr,
  input  logic nwen,
  input  logic nwaitext,
  output logic nws,
  output logic nrstb,
  output logic nwstb,
  output logic nberr,
  output logic busy
);

  localparam logic [3:0] MEM_WS_C  = 4'(MEM_WS);
  localparam logic [3:0] IO_WS_C   = 4'(IO_WS);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic       wr_q, wr_d;
  logic       nberr_q, nberr_d;

  logic       space_s, rd_s, wr_s, req_s, illegal_s, cnt_zero_s, tmo_s;
  logic [3:0] ws_s;
  logic       nws_s, nrstb_s, nwstb_s;

  // Request decode; IO space wins when both space selects are low.
  always_comb begin
    space_s    = !nmem || !nio;
    rd_s       = !nr && nwen;
    wr_s       = nr && !nwen;
    req_s      = space_s && (rd_s || wr_s);
    illegal_s  = space_s && !nr && !nwen;
    ws_s       = !nio ? IO_WS_C : MEM_WS_C;
    cnt_zero_s = (cnt_q == 4'd0);
    tmo_s      = (state_q == ST_WAIT) && cnt_zero_s && !nwaitext && (tcnt_q == TIMEOUT_C);
  end

  // Next-state, counter and strobe logic for the bus cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tcnt_d  = tcnt_q;
    wr_d    = wr_q;
    nberr_d = 1'b1;
    nws_s   = 1'b1;
    nrstb_s = 1'b1;
    nwstb_s = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (illegal_s) begin
          nberr_d = 1'b0;
        end else if (req_s) begin
          wr_d    = wr_s;
          nrstb_s = !rd_s;
          if ((ws_s != 4'd0) || !nwaitext) begin
            nws_s   = 1'b0;
            cnt_d   = (ws_s == 4'd0) ? 4'd0 : ws_s - 4'd1;
            tcnt_d  = 8'd0;
            state_d = ST_WAIT;
          end else begin
            nwstb_s = !wr_s;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (tmo_s) begin
          // Forced release: the sequencer moves on, the error follows a cycle later.
          nberr_d = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_zero_s && nwaitext) begin
          nrstb_s = wr_q;
          nwstb_s = !wr_q;
          state_d = ST_DONE;
        end else begin
          nws_s   = 1'b0;
          nrstb_s = wr_q;
          if (!cnt_zero_s) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            tcnt_d = tcnt_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk4 or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      tcnt_q  <= 8'd0;
      wr_q    <= 1'b0;
      nberr_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tcnt_q  <= tcnt_d;
      wr_q    <= wr_d;
      nberr_q <= nberr_d;
    end
  end

  // Reset releases the handshake outputs immediately, independent of the decode.
  assign nws   = nws_s   || !nreset;
  assign nrstb = nrstb_s || !nreset;
  assign nwstb = nwstb_s || !nreset;
  assign busy  = nreset && (state_q != ST_IDLE);
  assign nberr = nberr_q;

endmodule

// File: tb/tb_bus_wait_responder.sv
// Randomized bench for bus_wait_responder: each transaction's per-cycle outputs
// are compared with a cycle-index model of the wait/strobe rules.
module tb_bus_wait_responder;

  localparam int MWS = 0;
  localparam int IWS = 2;
  localparam int TMO = 8;

  logic clk4 = 1'b0;
  logic nreset, nmem, nio, nr, nwen, nwaitext;
  logic nws, nrstb, nwstb, nberr, busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  bit         ext_a [0:63];
  logic [4:0] obs_a [0:63];
  logic [4:0] exp_a [0:63];

  bus_wait_responder #(.MEM_WS(MWS), .IO_WS(IWS), .TIMEOUT(TMO)) dut (
    .clk4(clk4), .nreset(nreset), .nmem(nmem), .nio(nio), .nr(nr), .nwen(nwen),
    .nwaitext(nwaitext), .nws(nws), .nrstb(nrstb), .nwstb(nwstb), .nberr(nberr), .busy(busy)
  );

  always #5 clk4 = ~clk4;

  task automatic set_idle();
    nmem = 1'b1; nio = 1'b1; nr = 1'b1; nwen = 1'b1; nwaitext = 1'b1;
  endtask

  // Stall lasts for the programmed wait states plus extra cycles the device
  // holds nwaitext low after them; extra cycles are capped at TMO.
  task automatic model_txn(input int ws, input bit wr, output int n);
    int  extra = 0;
    int  rel = -1;
    bit  tmo = 1'b0;
    for (int k = 0; k < 60 && rel < 0; k++) begin
      if (k == 0) begin
        if (ws == 0 && ext_a[0]) rel = 0;
      end else if (k >= ws) begin
        if (!ext_a[k]) begin
          if (extra == TMO) begin rel = k; tmo = 1'b1; end
          else extra++;
        end else begin
          rel = k;
        end
      end
    end
    n = rel + 3;
    for (int k = 0; k < n; k++) begin
      exp_a[k][4] = (k < rel) ? 1'b0 : 1'b1;
      exp_a[k][3] = (!wr && k <= rel && !(tmo && k == rel)) ? 1'b0 : 1'b1;
      exp_a[k][2] = (wr && k == rel && !tmo) ? 1'b0 : 1'b1;
      exp_a[k][1] = (k >= 1 && k <= rel + 1) ? 1'b1 : 1'b0;
      exp_a[k][0] = (tmo && k == rel + 1) ? 1'b0 : 1'b1;
    end
  endtask

  // Request in cycle 0, junk on the request lines afterwards, idle in the last cycle.
  task automatic run_txn(input logic m, input logic io, input logic r, input logic w, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk4); #1;
      if (k == 0) begin
        nmem = m; nio = io; nr = r; nwen = w;
      end else if (k < n - 1) begin
        nmem = 1'($urandom); nio = 1'($urandom); nr = 1'($urandom); nwen = 1'($urandom);
      end else begin
        nmem = 1'b1; nio = 1'b1; nr = 1'b1; nwen = 1'b1;
      end
      nwaitext = ext_a[k];
      @(negedge clk4);
      obs_a[k] = {nws, nrstb, nwstb, busy, nberr};
    end
  endtask

  task automatic test_reset();
    int n;
    nreset = 1'b0; nmem = 1'b0; nio = 1'b1; nr = 1'b0; nwen = 1'b1; nwaitext = 1'b0;
    repeat (2) @(negedge clk4);
    total_cnt++;
    if ({nws, nrstb, nwstb, busy, nberr} !== 5'b11101)
      $display("FAIL reset_outputs: got %b expected %b", {nws, nrstb, nwstb, busy, nberr}, 5'b11101);
    else pass_cnt++;
    set_idle();
    nreset = 1'b1;
    for (int k = 0; k < 64; k++) ext_a[k] = 1'b1;
    model_txn(MWS, 1'b0, n);
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, n);
    for (int k = 0; k < n; k++) begin
      total_cnt++;
      if (obs_a[k] !== exp_a[k]) $display("FAIL reset_first_read cyc %0d: got %b expected %b", k, obs_a[k], exp_a[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_io_write();
    int n;
    int busy_cyc = 0;
    for (int k = 0; k < 64; k++) ext_a[k] = 1'b1;
    model_txn(IWS, 1'b1, n);
    run_txn(1'b1, 1'b0, 1'b1, 1'b0, n);
    for (int k = 0; k < n; k++) begin
      total_cnt++;
      if (obs_a[k] !== exp_a[k]) $display("FAIL io_write cyc %0d: got %b expected %b", k, obs_a[k], exp_a[k]);
      else pass_cnt++;
      if (obs_a[k][1] === 1'b1) busy_cyc++;
    end
    total_cnt++;
    if (busy_cyc !== 3) $display("FAIL io_write_busy_len: got %0d expected 3", busy_cyc);
    else pass_cnt++;
  endtask

  task automatic test_wait_ext();
    int n;
    for (int k = 0; k < 64; k++) ext_a[k] = !(k >= 1 && k <= 4);
    model_txn(MWS, 1'b0, n);
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, n);
    for (int k = 0; k < n; k++) begin
      total_cnt++;
      if (obs_a[k] !== exp_a[k]) $display("FAIL wait_ext cyc %0d: got %b expected %b", k, obs_a[k], exp_a[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_timeout();
    int n;
    for (int k = 0; k < 64; k++) ext_a[k] = 1'b0;
    model_txn(MWS, 1'b0, n);
    total_cnt++;
    if (n !== 1 + MWS + TMO + 3) $display("FAIL timeout_model_len: got %0d expected %0d", n, 1 + MWS + TMO + 3);
    else pass_cnt++;
    run_txn(1'b0, 1'b1, 1'b0, 1'b1, n);
    for (int k = 0; k < n; k++) begin
      total_cnt++;
      if (obs_a[k] !== exp_a[k]) $display("FAIL timeout cyc %0d: got %b expected %b", k, obs_a[k], exp_a[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal();
    int n;
    @(posedge clk4); #1;
    nmem = 1'b0; nio = 1'b1; nr = 1'b0; nwen = 1'b0; nwaitext = 1'b1;
    @(negedge clk4);
    total_cnt++;
    if ({nws, nrstb, nwstb, busy, nberr} !== 5'b11101)
      $display("FAIL illegal_req_cycle: got %b expected %b", {nws, nrstb, nwstb, busy, nberr}, 5'b11101);
    else pass_cnt++;
    @(posedge clk4); #1;
    set_idle();
    @(negedge clk4);
    total_cnt++;
    if ({busy, nberr} !== 2'b00) $display("FAIL illegal_berr_pulse: got %b expected %b", {busy, nberr}, 2'b00);
    else pass_cnt++;
    @(negedge clk4);
    total_cnt++;
    if (nberr !== 1'b1) $display("FAIL illegal_berr_end: got %b expected 1", nberr);
    else pass_cnt++;
    for (int k = 0; k < 64; k++) ext_a[k] = 1'b1;
    model_txn(IWS, 1'b0, n);
    run_txn(1'b0, 1'b0, 1'b0, 1'b1, n);
    for (int k = 0; k < n; k++) begin
      total_cnt++;
      if (obs_a[k] !== exp_a[k]) $display("FAIL both_space_io cyc %0d: got %b expected %b", k, obs_a[k], exp_a[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_wait();
    int n;
    @(posedge clk4); #1;
    nmem = 1'b1; nio = 1'b0; nr = 1'b0; nwen = 1'b1; nwaitext = 1'b1;
    @(posedge clk4); #1;
    @(negedge clk4);
    total_cnt++;
    if ({nws, nrstb, busy} !== 3'b001) $display("FAIL mid_wait_pre: got %b expected %b", {nws, nrstb, busy}, 3'b001);
    else pass_cnt++;
    #1 nreset = 1'b0;
    #1;
    total_cnt++;
    if ({nws, nrstb, nwstb, busy} !== 4'b1110) $display("FAIL mid_wait_reset: got %b expected %b", {nws, nrstb, nwstb, busy}, 4'b1110);
    else pass_cnt++;
    set_idle();
    @(negedge clk4);
    nreset = 1'b1;
    for (int k = 0; k < 64; k++) ext_a[k] = 1'b1;
    model_txn(IWS, 1'b0, n);
    run_txn(1'b1, 1'b0, 1'b0, 1'b1, n);
    for (int k = 0; k < n; k++) begin
      total_cnt++;
      if (obs_a[k] !== exp_a[k]) $display("FAIL post_reset_full_ws cyc %0d: got %b expected %b", k, obs_a[k], exp_a[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int n, sp, ws;
    bit wr, hold;
    logic m, io;
    for (int t = 0; t < 30; t++) begin
      sp = $urandom_range(0, 2);
      wr = 1'($urandom);
      hold = ($urandom_range(0, 4) == 0);
      m  = (sp == 1) ? 1'b1 : 1'b0;
      io = (sp == 0) ? 1'b1 : 1'b0;
      ws = (sp == 0) ? MWS : IWS;
      for (int k = 0; k < 64; k++) ext_a[k] = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      model_txn(ws, wr, n);
      run_txn(m, io, wr, !wr, n);
      for (int k = 0; k < n; k++) begin
        total_cnt++;
        if (obs_a[k] !== exp_a[k]) $display("FAIL random t%0d cyc %0d: got %b expected %b", t, k, obs_a[k], exp_a[k]);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_io_write();
    test_wait_ext();
    test_timeout();
    test_illegal();
    test_reset_mid_wait();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
